// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths.
//   uart_state_e - transmit frame sequencer states
//   PAR_*        - encoding of the PARITY parameter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period timer for the UART serializer.
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   load     - capture div_in as the bit period for the coming frame
//   div_in   - clocks per bit (already clamped to >= 2 by the caller)
//   restart  - zero the count (issued on every state change)
//   bit_end  - one-cycle strobe in the last clock of each bit period
module uart_baud_counter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 restart,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load) div_q <= div_in;
      // wrap at the terminal count so consecutive bits of one state need no restart
      if (restart || bit_end) cnt_q <= '0;
      else                    cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

  assign bit_end = (cnt_q == div_q - DIV_WIDTH'(1));

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops words from the transmit FIFO and sends them as
// asynchronous frames (start, LSB-first data, optional parity, 1-2 stop bits).
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   enable     - permits starting a new frame
//   baud_div   - clocks per bit (0 and 1 are treated as 2)
//   fifo_empty - FIFO empty flag
//   fifo_rd    - FIFO pop strobe, high only in FETCH
//   fifo_dout  - FIFO read data, valid during FETCH
//   tx         - registered serial line, idles high
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse in the last cycle of the frame
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | line high, waiting for enable and a non-empty FIFO
// ST_FETCH  | one-cycle pop; word and bit period latched at its end
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (only when PARITY != PAR_NONE)
// ST_STOP   | STOP_BITS stop bits (high); done on the last cycle
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  done_c;
  logic                  bit_end;
  logic [DIV_WIDTH-1:0]  div_eff;

  assign div_eff = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;

  uart_baud_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == ST_FETCH),
    .div_in  (div_eff),
    .restart (state_d != state_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        shreg_d = fifo_dout;
        idx_d   = '0;
        par_d   = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          par_d   = par_q ^ shreg_q[0];
          shreg_d = shreg_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // line level follows the state being entered so tx and state move together
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = (PARITY == PAR_ODD) ? ~par_d : par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign fifo_rd = (state_q == ST_FETCH);
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_c;
  assign tx      = tx_q;

endmodule
